// File: rtl/ahb_reg_bridge.sv
// AHB-Lite slave bridging single word transfers onto the simple register bus.
// Every accepted AHB transfer becomes one register-bus request; reads are guarded by a response timer.
module ahb_reg_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          REG_BYTES = 40,
    parameter int          TIMEOUT   = 16
) (
    input  logic        i_clk_ahb,
    input  logic        i_rst_ahb,
    input  logic        i_hsel,
    input  logic [31:0] i_haddr,
    input  logic [1:0]  i_htrans,
    input  logic        i_hwrite,
    input  logic [2:0]  i_hsize,
    input  logic [31:0] i_hwdata,
    input  logic        i_hready,
    output logic        o_hreadyout,
    output logic        o_hresp,
    output logic [31:0] o_hrdata,
    output logic [31:0] o_address,
    output logic        o_rd0_wr1,
    output logic [31:0] o_wr_data,
    output logic        o_valid,
    input  logic [31:0] i_rd_data,
    input  logic        i_rd_valid,
    input  logic        i_ready,
    output logic        o_timeout
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    // Register-bus handshake: a request is presented while o_valid=1 and is
    // consumed on the rising edge where i_ready=1; address, direction and
    // write data stay constant until then. Read data arrives later on
    // i_rd_valid and is only looked at while waiting for it.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_CAP   = 3'd1,
        S_WR_ISSUE = 3'd2,
        S_RD_ISSUE = 3'd3,
        S_RD_WAIT  = 3'd4,
        S_ERR1     = 3'd5,
        S_ERR2     = 3'd6
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic          timer_done;
    logic          accept;
    logic          legal;
    logic          in_window;
    logic [32:0]   addr_ext;
    logic [32:0]   win_lo;
    logic [32:0]   win_hi;
    logic [31:0]   offset;

    // ERR2 completes the error response with hreadyout=1, so it also accepts a new address phase.
    assign accept = ((state == S_IDLE) || (state == S_ERR2)) &&
                    i_hsel && i_htrans[1] && i_hready;

    // Window bounds in 33 bits so a window touching the top of memory cannot wrap.
    assign addr_ext   = {1'b0, i_haddr};
    assign win_lo     = {1'b0, BASE_ADDR};
    assign win_hi     = {1'b0, BASE_ADDR} + 33'(REG_BYTES);
    assign in_window  = (addr_ext >= win_lo) && (addr_ext < win_hi);
    assign legal      = (i_hsize == 3'b010) && (i_haddr[1:0] == 2'b00) && in_window;
    assign offset     = i_haddr - BASE_ADDR;
    assign timer_done = (timer == TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge i_clk_ahb) begin
        if (i_rst_ahb) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_ERR2: begin
                state_nxt = S_IDLE;
                if (accept) begin
                    if (!legal) begin
                        state_nxt = S_ERR1;
                    end else if (i_hwrite) begin
                        state_nxt = S_WR_CAP;
                    end else begin
                        state_nxt = S_RD_ISSUE;
                    end
                end
            end
            S_WR_CAP: begin
                state_nxt = S_WR_ISSUE;
            end
            S_WR_ISSUE: begin
                if (i_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            S_RD_ISSUE: begin
                if (i_ready) begin
                    state_nxt = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (i_rd_valid) begin
                    state_nxt = S_IDLE;
                end else if (timer_done) begin
                    state_nxt = S_ERR1;
                end
            end
            S_ERR1: begin
                state_nxt = S_ERR2;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        o_hreadyout = 1'b1;
        o_hresp     = 1'b0;
        o_valid     = 1'b0;
        o_rd0_wr1   = 1'b0;
        case (state)
            S_WR_CAP: begin
                o_hreadyout = 1'b0;
            end
            S_WR_ISSUE: begin
                o_hreadyout = 1'b0;
                o_valid     = 1'b1;
                o_rd0_wr1   = 1'b1;
            end
            S_RD_ISSUE: begin
                o_hreadyout = 1'b0;
                o_valid     = 1'b1;
            end
            S_RD_WAIT: begin
                o_hreadyout = 1'b0;
            end
            S_ERR1: begin
                o_hreadyout = 1'b0;
                o_hresp     = 1'b1;
            end
            S_ERR2: begin
                o_hresp = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; the offset is only taken for legal transfers so it stays inside the window.
    always_ff @(posedge i_clk_ahb) begin
        if (i_rst_ahb) begin
            o_address <= '0;
            o_wr_data <= '0;
            o_hrdata  <= '0;
            o_timeout <= 1'b0;
            timer     <= '0;
        end else begin
            if (accept && legal) begin
                o_address <= offset;
            end
            if (state == S_WR_CAP) begin
                o_wr_data <= i_hwdata;
            end
            if ((state == S_RD_WAIT) && i_rd_valid) begin
                o_hrdata <= i_rd_data;
            end
            if ((state == S_RD_WAIT) && !i_rd_valid && timer_done) begin
                o_timeout <= 1'b1;
            end
            // Timer counts only in RD_WAIT and is zero on entry; it saturates rather than wraps.
            if ((state == S_RD_WAIT) && !timer_done) begin
                timer <= timer + 1'b1;
            end else if (state != S_RD_WAIT) begin
                timer <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ahb_reg_bridge.sv
// Directed bench for ahb_reg_bridge with a small register-file responder model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ahb_reg_bridge;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic [31:0] address;
    logic        rd0_wr1;
    logic [31:0] wr_data;
    logic        valid;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        ready;
    logic        timeout;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem[16];

    // Results of the last transfer
    int          r_waits;
    int          r_valid_cycles;
    int          r_err_low;
    logic        r_hresp;
    logic        r_stable;
    logic [31:0] r_addr;
    logic        r_dir;
    logic [31:0] r_wdata;

    ahb_reg_bridge #(
        .BASE_ADDR (BASE),
        .REG_BYTES (40),
        .TIMEOUT   (16)
    ) dut (
        .i_clk_ahb   (clk),
        .i_rst_ahb   (rst),
        .i_hsel      (hsel),
        .i_haddr     (haddr),
        .i_htrans    (htrans),
        .i_hwrite    (hwrite),
        .i_hsize     (hsize),
        .i_hwdata    (hwdata),
        .i_hready    (hready),
        .o_hreadyout (hreadyout),
        .o_hresp     (hresp),
        .o_hrdata    (hrdata),
        .o_address   (address),
        .o_rd0_wr1   (rd0_wr1),
        .o_wr_data   (wr_data),
        .o_valid     (valid),
        .i_rd_data   (rd_data),
        .i_rd_valid  (rd_valid),
        .i_ready     (ready),
        .o_timeout   (timeout)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Entered at a falling edge where the bridge can take an address phase;
    // returns at the falling edge of the completion cycle.
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wdata, input int stall, input logic rd_en);
        logic        fire_prev;
        logic [31:0] fire_addr;
        logic        done;
        fire_prev      = 1'b0;
        fire_addr      = '0;
        done           = 1'b0;
        r_waits        = 0;
        r_valid_cycles = 0;
        r_err_low      = 0;
        r_hresp        = 1'b0;
        r_stable       = 1'b1;
        r_addr         = '0;
        r_dir          = 1'b0;
        r_wdata        = '0;
        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = wr;
        haddr  = addr;
        hsize  = size;
        hready = 1'b1;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            @(negedge clk);
            if (hreadyout) begin
                r_hresp  = hresp;
                ready    = 1'b0;
                rd_valid = 1'b0;
                done     = 1'b1;
            end else begin
                hsel   = 1'b0;
                htrans = 2'b00;
                hwdata = wdata;
                r_waits++;
                if (hresp) r_err_low++;
                rd_valid = 1'b0;
                if (fire_prev) begin
                    rd_valid = rd_en;
                    rd_data  = mem[fire_addr[5:2]];
                end
                fire_prev = 1'b0;
                if (valid) begin
                    r_valid_cycles++;
                    if (r_valid_cycles == 1) begin
                        r_addr  = address;
                        r_dir   = rd0_wr1;
                        r_wdata = wr_data;
                    end else if (address !== r_addr || rd0_wr1 !== r_dir || wr_data !== r_wdata) begin
                        r_stable = 1'b0;
                    end
                    ready = (r_valid_cycles > stall);
                    if (ready && rd0_wr1) mem[address[5:2]] = wr_data;
                    fire_prev = ready && !rd0_wr1;
                    fire_addr = address;
                end else begin
                    ready = 1'b0;
                end
            end
        end
        if (!done) check("xfer_budget", 32'd1, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[7] = 32'h03FF_FFFF;
        rst = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'b010; hwdata = '0; hready = 1'b1; rd_data = '0; rd_valid = 1'b0; ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_hreadyout", 32'(hreadyout), 32'd1);
        check("rst_hresp",     32'(hresp),     32'd0);
        check("rst_hrdata",    hrdata,         32'd0);
        check("rst_address",   address,        32'd0);
        check("rst_wr_data",   wr_data,        32'd0);
        check("rst_dir",       32'(rd0_wr1),   32'd0);
        check("rst_valid",     32'(valid),     32'd0);
        check("rst_timeout",   32'(timeout),   32'd0);

        // Single write
        do_xfer(1'b1, BASE + 32'h04, 3'b010, 32'hA5A5_1234, 0, 1'b1);
        check("wr_valid_cycles", 32'(r_valid_cycles), 32'd1);
        check("wr_address",      r_addr,              32'h04);
        check("wr_dir",          32'(r_dir),          32'd1);
        check("wr_data",         r_wdata,             32'hA5A5_1234);
        check("wr_waits",        32'(r_waits),        32'd2);
        check("wr_hresp",        32'(r_hresp),        32'd0);

        // Single read with one-cycle responder
        exp_q.push_back(32'h03FF_FFFF);
        do_xfer(1'b0, BASE + 32'h1C, 3'b010, 32'h0, 0, 1'b1);
        check("rd_waits",   32'(r_waits),        32'd2);
        check("rd_hresp",   32'(r_hresp),        32'd0);
        check("rd_address", r_addr,              32'h1C);
        check("rd_dir",     32'(r_dir),          32'd0);
        check("rd_data",    hrdata,              exp_q.pop_front());

        // IDLE and BUSY transfers get zero-wait OKAY
        for (int t = 0; t < 2; t++) begin
            hsel = 1'b1; htrans = 2'(t); hwrite = 1'b1; haddr = BASE + 32'h08;
            @(negedge clk);
            check("idle_hreadyout", 32'(hreadyout), 32'd1);
            check("idle_valid",     32'(valid),     32'd0);
            check("idle_hresp",     32'(hresp),     32'd0);
        end
        hsel = 1'b0; htrans = 2'b00;

        // Stalled write followed back-to-back by a read of the same register
        do_xfer(1'b1, BASE + 32'h20, 3'b010, 32'h0000_0001, 5, 1'b1);
        check("stall_valid_cycles", 32'(r_valid_cycles), 32'd6);
        check("stall_stable",       32'(r_stable),       32'd1);
        check("stall_waits",        32'(r_waits),        32'd7);
        check("stall_wdata",        r_wdata,             32'h1);
        exp_q.push_back(32'h0000_0001);
        do_xfer(1'b0, BASE + 32'h20, 3'b010, 32'h0, 0, 1'b1);
        check("b2b_waits", 32'(r_waits), 32'd2);
        check("b2b_data",  hrdata,       exp_q.pop_front());

        // Read with no response
        do_xfer(1'b0, BASE + 32'h00, 3'b010, 32'h0, 0, 1'b0);
        check("to_waits",   32'(r_waits),   32'd18);
        check("to_err1",    32'(r_err_low), 32'd1);
        check("to_hresp",   32'(r_hresp),   32'd1);
        check("to_flag",    32'(timeout),   32'd1);
        check("to_hrdata",  hrdata,         32'h1);

        // Illegal transfers, back-to-back, each taken in the ERR2 of the previous one
        do_xfer(1'b0, BASE + 32'h28, 3'b010, 32'h0, 0, 1'b1);
        check("ill_range_waits", 32'(r_waits),        32'd1);
        check("ill_range_err1",  32'(r_err_low),      32'd1);
        check("ill_range_hresp", 32'(r_hresp),        32'd1);
        check("ill_range_valid", 32'(r_valid_cycles), 32'd0);
        do_xfer(1'b1, BASE + 32'h02, 3'b010, 32'hFFFF_FFFF, 0, 1'b1);
        check("ill_align_waits", 32'(r_waits),        32'd1);
        check("ill_align_hresp", 32'(r_hresp),        32'd1);
        check("ill_align_valid", 32'(r_valid_cycles), 32'd0);
        do_xfer(1'b0, BASE + 32'h08, 3'b000, 32'h0, 0, 1'b1);
        check("ill_size_waits",  32'(r_waits),        32'd1);
        check("ill_size_hresp",  32'(r_hresp),        32'd1);
        check("ill_size_valid",  32'(r_valid_cycles), 32'd0);
        check("ill_hrdata_kept", hrdata,              32'h1);
        exp_q.push_back(32'h03FF_FFFF);
        do_xfer(1'b0, BASE + 32'h1C, 3'b010, 32'h0, 0, 1'b1);
        check("after_err_waits", 32'(r_waits), 32'd2);
        check("after_err_hresp", 32'(r_hresp), 32'd0);
        check("after_err_data",  hrdata,       exp_q.pop_front());
        check("timeout_sticky",  32'(timeout), 32'd1);

        // Reset during RD_WAIT
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = BASE + 32'h0C; hsize = 3'b010;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00;
        check("rst_mid_issue", 32'(valid), 32'd1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("rst_mid_wait", 32'(hreadyout), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_valid",     32'(valid),     32'd0);
        check("rst_mid_hreadyout", 32'(hreadyout), 32'd1);
        check("rst_mid_hresp",     32'(hresp),     32'd0);
        check("rst_mid_timeout",   32'(timeout),   32'd0);
        rst = 1'b0; rd_valid = 1'b1; rd_data = 32'hDEAD_BEEF;
        @(negedge clk);
        rd_valid = 1'b0;
        check("stray_rd_valid", hrdata,          32'd0);
        check("stray_ready",    32'(hreadyout),  32'd1);
        exp_q.push_back(32'hA5A5_1234);
        do_xfer(1'b0, BASE + 32'h04, 3'b010, 32'h0, 0, 1'b1);
        check("post_rst_waits", 32'(r_waits), 32'd2);
        check("post_rst_hresp", 32'(r_hresp), 32'd0);
        check("post_rst_data",  hrdata,       exp_q.pop_front());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ahb_reg_bridge.md
Name: ahb_reg_bridge

Overview:
- AHB-Lite slave that acts as the initiator on the simple register bus (address, rd0/wr1, write data, valid / read data, read valid, ready) used by the SPI flash controller register file.
- Converts each AHB word transfer into exactly one register-bus transaction.
- Returns read data and OKAY/ERROR responses to the AHB master.
- Guards against a hung responder with a read-response timeout.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte base of the register window.
- REG_BYTES, 40: window size in bytes; valid offsets are 0x00..0x24.
- TIMEOUT, 16: max cycles in RD_WAIT before an ERROR response; must be at least 2.

Ports:
- i_clk_ahb  in  1  clock, all logic on the rising edge
- i_rst_ahb  in  1  synchronous active-high reset
- i_hsel  in  1  AHB slave select
- i_haddr  in  32  AHB address
- i_htrans  in  2  AHB transfer type; bit 1 set means NONSEQ or SEQ
- i_hwrite  in  1  AHB write
- i_hsize  in  3  AHB size; only 3'b010 (word) is legal
- i_hwdata  in  32  AHB write data, valid in the data phase
- i_hready  in  1  AHB bus ready in
- o_hreadyout  out  1  slave ready
- o_hresp  out  1  0 = OKAY, 1 = ERROR
- o_hrdata  out  32  read data
- o_address  out  32  register-bus byte offset (HADDR − BASE_ADDR)
- o_rd0_wr1  out  1  register-bus direction
- o_wr_data  out  32  register-bus write data
- o_valid  out  1  register-bus request valid
- i_rd_data  in  32  register-bus read data
- i_rd_valid  in  1  register-bus read data valid
- i_ready  in  1  register-bus ready
- o_timeout  out  1  sticky flag: a read timed out; cleared only by reset

Behaviour:
- Reset, applied on a clock edge while i_rst_ahb=1:
  - State IDLE; o_hreadyout=1; o_hresp=0.
  - o_hrdata, o_address and o_wr_data are 0.
  - o_rd0_wr1, o_valid and o_timeout are 0.
  - Reset mid-transaction abandons it; o_valid is 0 from that edge.
- Address phase is accepted in IDLE when i_hsel & i_htrans[1] & i_hready. The bridge latches the offset, direction and a legality check.
- Legal transfer requires all of:
  - i_hsize = 3'b010;
  - i_haddr[1:0] = 0;
  - BASE_ADDR ≤ i_haddr < BASE_ADDR + REG_BYTES.
- If the transfer is illegal, go to ERR1 and never assert o_valid.
- IDLE/BUSY transfers, or i_hsel=0, get a zero-wait OKAY with no state change.
- States and outputs:
  - IDLE: o_hreadyout=1, o_hresp=0.
  - WR_CAP: o_hreadyout=0; capture i_hwdata into o_wr_data; next state WR_ISSUE.
  - WR_ISSUE: o_valid=1, o_rd0_wr1=1. Hold o_address and o_wr_data stable until i_ready=1 is sampled; then o_valid=0 and go to IDLE.
  - RD_ISSUE: o_valid=1, o_rd0_wr1=0. Hold until i_ready=1 is sampled; then go to RD_WAIT and clear the timer.
  - RD_WAIT: o_valid=0; the timer increments each cycle.
    - If i_rd_valid=1: o_hrdata <= i_rd_data, go to IDLE.
    - Else if timer = TIMEOUT−1: set o_timeout and go to ERR1.
    - i_rd_valid takes priority over the timeout in the same cycle.
  - ERR1: o_hreadyout=0, o_hresp=1. Next state ERR2.
  - ERR2: o_hreadyout=1, o_hresp=1. Next state IDLE. Per AHB, a new address phase is accepted in ERR2 exactly as in IDLE.
- Latency with i_ready=1 and a 1-cycle read responder:
  - Write data phase: 3 cycles (WR_CAP, WR_ISSUE, IDLE completion).
  - Read data phase: 3 cycles (RD_ISSUE, RD_WAIT, IDLE completion).
  - Each extra i_ready=0 cycle adds one cycle.
- Back-to-back: the next address phase is taken in the IDLE or ERR2 cycle that completes the previous transfer. There are no gaps beyond those listed above.
- o_hrdata keeps its last value after writes and errors.
- i_rd_valid outside RD_WAIT is ignored.
- Timer width is $clog2(TIMEOUT)+1; it never wraps.
- o_address has width 32, with bits above $clog2(REG_BYTES) equal to zero.

Test Plan:
- Write 0xA5A5_1234 to BASE+0x04 with i_ready=1 -> one o_valid cycle with o_address=0x04, o_rd0_wr1=1, o_wr_data=0xA5A5_1234; o_hreadyout low 2 cycles; o_hresp=0.
- Read BASE+0x1C; the responder returns 0x03FF_FFFF one cycle after the request -> o_hrdata=0x03FF_FFFF in the completion cycle; 3-cycle data phase; OKAY.
- Write 0x1 to 0x20 back-to-back with a read of 0x20, responder held i_ready=0 for 5 cycles on the write -> o_valid, o_address and o_wr_data stable for 6 cycles; read issued right after; o_hrdata=0x1.
- Read with i_rd_valid never asserted, TIMEOUT=16 -> exactly 16 RD_WAIT cycles, then ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1); o_timeout=1 and stays 1.
- Access to BASE+0x28, BASE+0x02, and i_hsize=3'b000 -> two-cycle ERROR each; o_valid never asserted.
- Assert i_rst_ahb during RD_WAIT -> the next cycle shows o_valid=0, o_hreadyout=1, o_hresp=0, o_timeout=0; a later i_rd_valid is ignored; a subsequent read completes normally.
